// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: round-robin row drive, synchronized column sampling,
// one time-shared debounce counter for press and release, key code with valid strobe.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEB_CYCLES);

    localparam logic [1:0] SCAN    = 2'd0;
    localparam logic [1:0] DEB     = 2'd1;
    localparam logic [1:0] PRESSED = 2'd2;
    localparam logic [1:0] RELDEB  = 2'd3;

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST = BW'(DEB_CYCLES - 1);

    logic [3:0]    col_m_q, col_s_q;
    logic [1:0]    state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] db_cnt_q, db_cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          single;
    logic [1:0]    pat_col;

    // Exactly one low column; anything else (none or ghosting) is treated as no key.
    always_comb begin
        single = 1'b0;
        case (col_s_q)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single = 1'b1;
            default: single = 1'b0;
        endcase
    end

    always_comb begin
        pat_col = 2'd0;
        case (pat_q)
            4'b1101: pat_col = 2'd1;
            4'b1011: pat_col = 2'd2;
            4'b0111: pat_col = 2'd3;
            default: pat_col = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        div_cnt_d   = div_cnt_q;
        db_cnt_d    = db_cnt_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (!scan_en) begin
            state_d    = SCAN;
            row_idx_d  = 2'd0;
            div_cnt_d  = '0;
            db_cnt_d   = '0;
            key_down_d = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        if (single) begin
                            pat_d    = col_s_q;
                            db_cnt_d = '0;
                            state_d  = DEB;
                        end else begin
                            row_idx_d = row_idx_q + 2'd1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                DEB: begin
                    if (col_s_q == pat_q) begin
                        if (db_cnt_q == DEB_LAST) begin
                            state_d     = PRESSED;
                            key_code_d  = {row_idx_q, pat_col};
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                        end else begin
                            db_cnt_d = db_cnt_q + 1'b1;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                        div_cnt_d = '0;
                        state_d   = SCAN;
                    end
                end
                PRESSED: begin
                    if (col_s_q == 4'b1111) begin
                        db_cnt_d = '0;
                        state_d  = RELDEB;
                    end
                end
                default: begin
                    if (col_s_q == 4'b1111) begin
                        if (db_cnt_q == DEB_LAST) begin
                            state_d    = SCAN;
                            key_down_d = 1'b0;
                            row_idx_d  = row_idx_q + 2'd1;
                            div_cnt_d  = '0;
                        end else begin
                            db_cnt_d = db_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m_q     <= 4'b1111;
            col_s_q     <= 4'b1111;
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            div_cnt_q   <= '0;
            db_cnt_q    <= '0;
            pat_q       <= 4'b1111;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            col_m_q     <= col_in;
            col_s_q     <= col_m_q;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            div_cnt_q   <= div_cnt_d;
            db_cnt_q    <= db_cnt_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign row_out   = scan_en ? ~(4'b0001 << row_idx_q) : 4'b1111;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
endmodule
